cpu_step_ctrl: RTL and testbench

Front-panel execution controller for the single-cycle CPU board build. It takes already-debounced push-button levels and turns them into CPU clock-enable pulses. It supports manual single-step and free-run at a divided rate, and stops stepping when the CPU signals halt. It also cycles the seven-segment display page selector and counts executed steps for display.

---
 rtl/cpu_step_ctrl_pkg.sv | 14 +
 rtl/cpu_step_ctrl_key_edge.sv | 27 ++
 rtl/cpu_step_ctrl.sv | 126 ++++++++++++
 tb/tb_cpu_step_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_step_ctrl_pkg.sv
// Shared definitions for the front-panel step controller: FSM state encoding
// and the step-rate divider used on the board build.
package cpu_step_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  // 50 MHz board clock divided down to two steps per second in free-run.
  localparam int unsigned BOARD_RUN_DIV = 25_000_000;

endpackage

// File: rtl/cpu_step_ctrl_key_edge.sv
// Rising-edge detector for one debounced push-button level.
// History resets to 1 so a key held through reset release is not a press.
module key_edge (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);

  logic hist_q;
  logic hist_d;

  always_comb begin
    hist_d = key;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= 1'b1;
    end else begin
      hist_q <= hist_d;
    end
  end

  assign press = key & ~hist_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Front-panel execution controller: single-step, divided free-run and halt
// handling, plus display page selection and a saturating step counter.
module cpu_step_ctrl
  import cpu_step_ctrl_pkg::*;
#(
  parameter int RUN_DIV    = BOARD_RUN_DIV,
  parameter int DISP_PAGES = 4,
  parameter int PAGE_W     = 2,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_step,
  input  logic              key_run,
  input  logic              key_page,
  input  logic              cpu_halt,
  output logic              cpu_step_en,
  output logic              run_mode,
  output logic              halted,
  output logic [PAGE_W-1:0] page_sel,
  output logic [CNT_W-1:0]  step_count
);

  localparam int TIMER_W = $clog2(RUN_DIV);

  logic step_press;
  logic run_press;
  logic page_press;

  key_edge u_step_edge (.clk(clk), .rst(rst), .key(key_step), .press(step_press));
  key_edge u_run_edge  (.clk(clk), .rst(rst), .key(key_run),  .press(run_press));
  key_edge u_page_edge (.clk(clk), .rst(rst), .key(key_page), .press(page_press));

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                step_en_q, step_en_d;
  logic                run_mode_q, run_mode_d;
  logic                halted_q, halted_d;
  logic [PAGE_W-1:0]   page_q, page_d;
  logic [CNT_W-1:0]    count_q, count_d;

  // In RUN the priority is halt, then run press, then timer terminal count.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    step_en_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (run_press) begin
          state_d = ST_RUN;
        end else if (step_press) begin
          if (cpu_halt) begin
            state_d = ST_HALTED;
          end else begin
            step_en_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (cpu_halt) begin
          state_d = ST_HALTED;
          timer_d = '0;
        end else if (run_press) begin
          state_d = ST_IDLE;
          timer_d = '0;
        end else if (timer_q == TIMER_W'(RUN_DIV - 1)) begin
          step_en_d = 1'b1;
          timer_d   = '0;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      ST_HALTED: begin
        timer_d = '0;
        if (run_press) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    run_mode_d = (state_d == ST_RUN);
    halted_d   = (state_d == ST_HALTED);
    page_d     = page_q;
    count_d    = count_q;
    if (page_press) begin
      page_d = (page_q == PAGE_W'(DISP_PAGES - 1)) ? '0 : page_q + PAGE_W'(1);
    end
    if (step_en_d && !(&count_q)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      timer_q    <= '0;
      step_en_q  <= 1'b0;
      run_mode_q <= 1'b0;
      halted_q   <= 1'b0;
      page_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      step_en_q  <= step_en_d;
      run_mode_q <= run_mode_d;
      halted_q   <= halted_d;
      page_q     <= page_d;
      count_q    <= count_d;
    end
  end

  assign cpu_step_en = step_en_q;
  assign run_mode    = run_mode_q;
  assign halted      = halted_q;
  assign page_sel    = page_q;
  assign step_count  = count_q;

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Scoreboard bench for cpu_step_ctrl: directed scenarios followed by random
// key/halt traffic, checked cycle by cycle against a behavioural model.
module tb_cpu_step_ctrl;

  localparam int RUN_DIV    = 4;
  localparam int DISP_PAGES = 4;
  localparam int PAGE_W     = 2;
  // Narrow counter so saturation is reachable in a few hundred cycles.
  localparam int CNT_W      = 6;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              key_step, key_run, key_page, cpu_halt;
  logic              cpu_step_en, run_mode, halted;
  logic [PAGE_W-1:0] page_sel;
  logic [CNT_W-1:0]  step_count;

  always #5 clk = ~clk;

  cpu_step_ctrl #(
    .RUN_DIV(RUN_DIV), .DISP_PAGES(DISP_PAGES), .PAGE_W(PAGE_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .key_step(key_step), .key_run(key_run), .key_page(key_page),
    .cpu_halt(cpu_halt),
    .cpu_step_en(cpu_step_en), .run_mode(run_mode), .halted(halted),
    .page_sel(page_sel), .step_count(step_count)
  );

  typedef struct packed {
    logic              step_en;
    logic              run_mode;
    logic              halted;
    logic [PAGE_W-1:0] page;
    logic [CNT_W-1:0]  count;
  } rec_t;

  rec_t exp_q[$];
  int   n_compared = 0;
  int   n_failed   = 0;

  int m_mode, m_timer, m_page, m_count;
  bit m_prev_step, m_prev_run, m_prev_page;

  task automatic checkOutput(input string name, input rec_t got, input rec_t want);
    n_compared++;
    if (got !== want) begin
      n_failed++;
      $display("[TB] FAIL %s: got en=%0b run=%0b halt=%0b page=%0d cnt=%0d, expected en=%0b run=%0b halt=%0b page=%0d cnt=%0d",
               name, got.step_en, got.run_mode, got.halted, got.page, got.count,
               want.step_en, want.run_mode, want.halted, want.page, want.count);
    end
  endtask

  task automatic modelReset();
    m_mode      = M_IDLE;
    m_timer     = 0;
    m_page      = 0;
    m_count     = 0;
    m_prev_step = 1'b1;
    m_prev_run  = 1'b1;
    m_prev_page = 1'b1;
  endtask

  function automatic rec_t sampleDut();
    rec_t g;
    g.step_en  = cpu_step_en;
    g.run_mode = run_mode;
    g.halted   = halted;
    g.page     = page_sel;
    g.count    = step_count;
    return g;
  endfunction

  // Drive one cycle of inputs, predict the response of the coming edge,
  // then move on to the next falling edge.
  task automatic applyStimulus(input bit s, input bit r, input bit p, input bit h);
    rec_t e;
    bit sp, rp, pp, pulse;
    key_step = s;
    key_run  = r;
    key_page = p;
    cpu_halt = h;
    sp = s && !m_prev_step;
    rp = r && !m_prev_run;
    pp = p && !m_prev_page;
    m_prev_step = s;
    m_prev_run  = r;
    m_prev_page = p;
    pulse = 1'b0;
    if (m_mode == M_IDLE) begin
      if (rp) begin
        m_mode  = M_RUN;
        m_timer = 0;
      end else if (sp) begin
        if (h) m_mode = M_HALT;
        else   pulse  = 1'b1;
      end
    end else if (m_mode == M_RUN) begin
      if (h) begin
        m_mode  = M_HALT;
        m_timer = 0;
      end else if (rp) begin
        m_mode  = M_IDLE;
        m_timer = 0;
      end else if (m_timer == RUN_DIV - 1) begin
        pulse   = 1'b1;
        m_timer = 0;
      end else begin
        m_timer++;
      end
    end else begin
      if (rp) m_mode = M_IDLE;
    end
    if (pp) m_page = (m_page + 1) % DISP_PAGES;
    if (pulse && m_count < CNT_MAX) m_count++;
    e.step_en  = pulse;
    e.run_mode = (m_mode == M_RUN);
    e.halted   = (m_mode == M_HALT);
    e.page     = PAGE_W'(m_page);
    e.count    = CNT_W'(m_count);
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: every rising edge that has a prediction queued gets compared.
  initial begin : monitor
    rec_t want;
    int   cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        checkOutput($sformatf("cycle%0d", cyc), sampleDut(), want);
      end
      cyc++;
    end
  end

  initial begin : stimulus
    rec_t zero_rec;
    zero_rec = '0;
    key_step = 1'b1;
    key_run  = 1'b0;
    key_page = 1'b0;
    cpu_halt = 1'b0;
    rst      = 1'b1;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset_state", sampleDut(), zero_rec);
    rst = 1'b0;

    // Step key held through reset release, then a genuine press.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Run and step together: run wins, then free-run for 12 cycles.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    idle(12);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Halt coinciding with the terminal count, step ignored, run acknowledges.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Five page presses, the third with a step press in the same cycle.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(i == 2, 1'b0, 1'b1, 1'b0);
      idle(1);
    end

    // Free-run long enough to saturate the counter, then a manual step.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(300);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);

    // Asynchronous reset in RUN with the timer at 2.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    rst = 1'b1;
    modelReset();
    #1;
    checkOutput("async_reset", sampleDut(), zero_rec);
    @(negedge clk);
    rst = 1'b0;
    idle(6);

    // Random key and halt traffic.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
    end
    idle(4);

    repeat (3) @(negedge clk);
    n_compared++;
    if (exp_q.size() != 0) begin
      n_failed++;
      $display("[TB] FAIL drain: got %0d pending predictions, expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
